carrier_loop_ctrl: RTL and testbench

//  Sequences the 2nd-order carrier-sync loop filter in the QPSK demodulator.

---
 rtl/carrier_loop_ctrl.sv | 169 ++++++++++++++++
 tb/tb_carrier_loop_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/carrier_loop_ctrl.sv
// Carrier-sync loop sequencer for the QPSK demodulator.
// Qualifies phase-error samples, gear-shifts the loop filter between
// wide-band acquire and narrow-band track, and drives the filter strobes.
module carrier_loop_ctrl #(
    parameter int PE_W        = 17,
    parameter int COEF_W      = 16,
    parameter int C1_ACQ      = 1024,
    parameter int C2_ACQ      = 32,
    parameter int C1_TRK      = 256,
    parameter int C2_TRK      = 2,
    parameter int LOCK_TH     = 2048,
    parameter int UNLOCK_TH   = 4096,
    parameter int LOCK_CNT    = 64,
    parameter int UNLOCK_CNT  = 16,
    parameter int ACQ_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [PE_W-1:0]   phase_error,
    input  logic              pe_valid,
    output logic [COEF_W-1:0] loop_c1,
    output logic [COEF_W-1:0] loop_c2,
    output logic              lf_en,
    output logic              lf_clr,
    output logic              locked,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CLR  = 2'b01,
        ACQ  = 2'b10,
        TRK  = 2'b11
    } stateT;

    localparam int ACQ_W  = $clog2(ACQ_TIMEOUT + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic [ACQ_W-1:0]  ACQ_MAX    = ACQ_W'(ACQ_TIMEOUT);
    localparam logic [GOOD_W-1:0] GOOD_MAX   = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  BAD_MAX    = BAD_W'(UNLOCK_CNT);
    localparam logic [PE_W-1:0]   LOCK_LIM   = PE_W'(LOCK_TH);
    localparam logic [PE_W-1:0]   UNLOCK_LIM = PE_W'(UNLOCK_TH);

    stateT               state_q, state_d;
    logic [ACQ_W-1:0]    acqCnt_q, acqCnt_d;
    logic [GOOD_W-1:0]   goodCnt_q, goodCnt_d;
    logic [BAD_W-1:0]    badCnt_q, badCnt_d;
    logic [COEF_W-1:0]   loopC1_q, loopC1_d;
    logic [COEF_W-1:0]   loopC2_q, loopC2_d;
    logic                lfEn_q, lfEn_d;
    logic                lfClr_q, lfClr_d;
    logic                locked_q, locked_d;

    logic [PE_W-1:0]     peMag;
    logic                isGood;
    logic                isBad;

    // Unsigned magnitude: the most negative code maps to 2^(PE_W-1), which
    // still fits in PE_W unsigned bits, so no overflow handling is needed.
    always_comb begin
        peMag  = phase_error[PE_W-1] ? (~phase_error + PE_W'(1)) : phase_error;
        isGood = (peMag <= LOCK_LIM);
        isBad  = (peMag > UNLOCK_LIM);
    end

    // State register plus counters and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acqCnt_q  <= '0;
            goodCnt_q <= '0;
            badCnt_q  <= '0;
            loopC1_q  <= COEF_W'(C1_ACQ);
            loopC2_q  <= COEF_W'(C2_ACQ);
            lfEn_q    <= 1'b0;
            lfClr_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acqCnt_q  <= acqCnt_d;
            goodCnt_q <= goodCnt_d;
            badCnt_q  <= badCnt_d;
            loopC1_q  <= loopC1_d;
            loopC2_q  <= loopC2_d;
            lfEn_q    <= lfEn_d;
            lfClr_q   <= lfClr_d;
            locked_q  <= locked_d;
        end
    end

    // Next state and counters; enable low overrides everything and parks in IDLE.
    always_comb begin
        state_d   = state_q;
        acqCnt_d  = acqCnt_q;
        goodCnt_d = goodCnt_q;
        badCnt_d  = badCnt_q;
        if (!enable) begin
            state_d   = IDLE;
            acqCnt_d  = '0;
            goodCnt_d = '0;
            badCnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = CLR;
                    acqCnt_d  = '0;
                    goodCnt_d = '0;
                    badCnt_d  = '0;
                end
                CLR: begin
                    state_d   = ACQ;
                    acqCnt_d  = '0;
                    goodCnt_d = '0;
                    badCnt_d  = '0;
                end
                ACQ: begin
                    if (pe_valid) begin
                        acqCnt_d  = (acqCnt_q == ACQ_MAX) ? acqCnt_q : acqCnt_q + 1'b1;
                        goodCnt_d = !isGood ? '0 :
                                    (goodCnt_q == GOOD_MAX) ? goodCnt_q : goodCnt_q + 1'b1;
                        if (goodCnt_d == GOOD_MAX) begin
                            state_d   = TRK;
                            acqCnt_d  = '0;
                            goodCnt_d = '0;
                            badCnt_d  = '0;
                        end else if (acqCnt_d == ACQ_MAX) begin
                            state_d   = CLR;
                            acqCnt_d  = '0;
                            goodCnt_d = '0;
                        end
                    end
                end
                TRK: begin
                    if (pe_valid) begin
                        badCnt_d = !isBad ? '0 :
                                   (badCnt_q == BAD_MAX) ? badCnt_q : badCnt_q + 1'b1;
                        if (badCnt_d == BAD_MAX) begin
                            state_d   = ACQ;
                            acqCnt_d  = '0;
                            goodCnt_d = '0;
                            badCnt_d  = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output values follow the upcoming state; lf_en uses the state the sample arrived in.
    always_comb begin
        loopC1_d = (state_d == TRK) ? COEF_W'(C1_TRK) : COEF_W'(C1_ACQ);
        loopC2_d = (state_d == TRK) ? COEF_W'(C2_TRK) : COEF_W'(C2_ACQ);
        locked_d = (state_d == TRK);
        lfClr_d  = (state_d == CLR);
        lfEn_d   = pe_valid && enable && ((state_q == ACQ) || (state_q == TRK));
    end

    assign state   = state_q;
    assign loop_c1 = loopC1_q;
    assign loop_c2 = loopC2_q;
    assign lf_en   = lfEn_q;
    assign lf_clr  = lfClr_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_carrier_loop_ctrl.sv
// Self-checking bench for carrier_loop_ctrl: a reset/startup vector table,
// then hand-written sequences for lock, unlock, timeout and enable drop.
module tb_carrier_loop_ctrl;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CLR  = 2'b01;
    localparam logic [1:0] S_ACQ  = 2'b10;
    localparam logic [1:0] S_TRK  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [16:0] phase_error;
    logic        pe_valid;
    logic [15:0] loop_c1;
    logic [15:0] loop_c2;
    logic        lf_en;
    logic        lf_clr;
    logic        locked;
    logic [1:0]  state;

    typedef struct {
        logic [1:0]  st;
        logic [15:0] c1;
        logic [15:0] c2;
        logic        en;
        logic        clr;
        logic        lk;
        string       name;
    } expT;

    typedef struct {
        logic       rn;
        logic       en;
        logic       pv;
        int         pe;
        logic [1:0] st;
        logic       lfEn;
        logic       lfClr;
    } vecT;

    expT sbQ[$];
    int  errors    = 0;
    int  checks    = 0;
    int  lfEnCount = 0;

    carrier_loop_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .phase_error (phase_error),
        .pe_valid    (pe_valid),
        .loop_c1     (loop_c1),
        .loop_c2     (loop_c2),
        .lf_en       (lf_en),
        .lf_clr      (lf_clr),
        .locked      (locked),
        .state       (state)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Builds the expected record for a state: coefficients and locked follow
    // the state, lf_clr is high exactly in the clear cycle.
    function automatic expT mk(input logic [1:0] st, input logic lfEn, input string name);
        expT r;
        r.st   = st;
        r.c1   = (st == S_TRK) ? 16'd256 : 16'd1024;
        r.c2   = (st == S_TRK) ? 16'd2 : 16'd32;
        r.en   = lfEn;
        r.clr  = (st == S_CLR);
        r.lk   = (st == S_TRK);
        r.name = name;
        return r;
    endfunction

    // Pops the oldest expectation and compares it with the DUT outputs.
    task automatic checkOutput();
        expT e;
        checks++;
        if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard-empty: output seen with no expectation queued");
        end else begin
            e = sbQ.pop_front();
            if (state !== e.st || loop_c1 !== e.c1 || loop_c2 !== e.c2 ||
                lf_en !== e.en || lf_clr !== e.clr || locked !== e.lk) begin
                errors++;
                $display("[TB] FAIL %s: got st=%b c1=%0d c2=%0d en=%b clr=%b lk=%b, want st=%b c1=%0d c2=%0d en=%b clr=%b lk=%b",
                         e.name, state, loop_c1, loop_c2, lf_en, lf_clr, locked,
                         e.st, e.c1, e.c2, e.en, e.clr, e.lk);
            end
        end
        if (lf_en === 1'b1) lfEnCount++;
    endtask

    // Drives one cycle of inputs, queues the expectation, samples after the edge.
    task automatic applyStimulus(input logic rn, input logic en, input logic pv,
                                 input int pe, input expT e);
        @(negedge clk);
        rst_n       = rn;
        enable      = en;
        pe_valid    = pv;
        phase_error = 17'(pe);
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic drive(input logic pv, input int pe, input logic [1:0] st,
                         input logic lfEn, input string name);
        applyStimulus(1'b1, 1'b1, pv, pe, mk(st, lfEn, name));
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Main test sequence.
    initial begin
        vecT vecs[9];
        rst_n       = 1'b0;
        enable      = 1'b0;
        pe_valid    = 1'b0;
        phase_error = '0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 0,    S_IDLE, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 0,    S_IDLE, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 0,    S_IDLE, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 0,    S_CLR,  1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 0,    S_ACQ,  1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 0,    S_ACQ,  1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 0,    S_IDLE, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 0,    S_CLR,  1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 0,    S_ACQ,  1'b0, 1'b0};

        $display("[TB] startup vector table");
        for (int i = 0; i < 9; i++) begin
            expT e;
            e     = mk(vecs[i].st, vecs[i].lfEn, $sformatf("vec%0d", i));
            e.clr = vecs[i].lfClr;
            applyStimulus(vecs[i].rn, vecs[i].en, vecs[i].pv, vecs[i].pe, e);
        end

        $display("[TB] lock with 64 samples at +2048");
        lfEnCount = 0;
        for (int i = 0; i < 64; i++)
            drive(1'b1, 2048, (i == 63) ? S_TRK : S_ACQ, 1'b1, $sformatf("lock64_%0d", i));
        drive(1'b0, 0, S_TRK, 1'b0, "lock64_idle");
        checkCount("lock64_lf_en_pulses", lfEnCount, 64);

        $display("[TB] unlock after 16 bad samples");
        for (int i = 0; i < 15; i++)
            drive(1'b1, -65536, S_TRK, 1'b1, $sformatf("bad15_%0d", i));
        drive(1'b1, 0, S_TRK, 1'b1, "bad_reset");
        for (int i = 0; i < 16; i++)
            drive(1'b1, 4097, (i == 15) ? S_ACQ : S_TRK, 1'b1, $sformatf("bad16_%0d", i));
        drive(1'b0, 0, S_ACQ, 1'b0, "unlock_idle");

        $display("[TB] good run broken by one bad sample");
        for (int i = 0; i < 63; i++) begin
            drive(1'b1, (i % 2 == 0) ? 2048 : -2048, S_ACQ, 1'b1, $sformatf("goodA_%0d", i));
            drive(1'b0, 0, S_ACQ, 1'b0, $sformatf("gapA_%0d", i));
        end
        drive(1'b1, -2049, S_ACQ, 1'b1, "break_sample");
        for (int i = 0; i < 63; i++)
            drive(1'b1, 100, S_ACQ, 1'b1, $sformatf("goodB_%0d", i));
        drive(1'b1, -7, S_TRK, 1'b1, "goodB_64th");

        $display("[TB] unlock threshold boundary");
        for (int i = 0; i < 15; i++)
            drive(1'b1, 4097, S_TRK, 1'b1, $sformatf("badC_%0d", i));
        drive(1'b1, 4096, S_TRK, 1'b1, "edge4096");
        for (int i = 0; i < 16; i++)
            drive(1'b1, -4097, (i == 15) ? S_ACQ : S_TRK, 1'b1, $sformatf("badD_%0d", i));

        $display("[TB] acquire timeout");
        for (int i = 0; i < 4096; i++)
            drive(1'b1, 4000, (i == 4095) ? S_CLR : S_ACQ, 1'b1, $sformatf("tmo_%0d", i));
        drive(1'b1, 0, S_ACQ, 1'b0, "clr_sample_ignored");
        for (int i = 0; i < 4032; i++)
            drive(1'b1, -4000, S_ACQ, 1'b1, $sformatf("post_%0d", i));
        for (int i = 0; i < 64; i++)
            drive(1'b1, 2048, (i == 63) ? S_TRK : S_ACQ, 1'b1, $sformatf("prio_%0d", i));

        $display("[TB] enable drop during track");
        applyStimulus(1'b1, 1'b0, 1'b1, 0, mk(S_IDLE, 1'b0, "endrop_0"));
        applyStimulus(1'b1, 1'b0, 1'b1, 0, mk(S_IDLE, 1'b0, "endrop_1"));
        applyStimulus(1'b1, 1'b1, 1'b1, 0, mk(S_CLR, 1'b0, "restart_clr"));
        applyStimulus(1'b1, 1'b1, 1'b0, 0, mk(S_ACQ, 1'b0, "restart_acq"));

        checkCount("scoreboard_leftover", sbQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
